instr_rom_responder: RTL

- Instruction-memory responder serving the fetch side of the CPU control FSM.
- Accepts a read strobe plus the PC address, and returns the instruction word with a data-valid pulse after a programmable latency.
- Includes a program-load write port so the testbench or a bootloader can fill memory before or between runs.
- Sits between the control FSM (pc, rom_read_enable) and the instruction register load path.

---
 rtl/instr_rom_responder_if.sv | 38 +++
 rtl/instr_rom_responder.sv | 97 +++++++++
 2 files changed

// File: rtl/instr_rom_responder_if.sv
// Fetch-side bus between the control FSM and the instruction ROM responder.
// ROM_PARITY_EN adds the parity_err response and the prog_par_inv write-side fault-injection bit.
interface instr_rom_responder_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) ();
  logic              rom_read_enable;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic              rd_overrun;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
`ifdef ROM_PARITY_EN
  logic              parity_err;
  logic              prog_par_inv;

  modport master (
    output rom_read_enable, pc, prog_we, prog_addr, prog_data, prog_par_inv,
    input  rd_data, rd_valid, busy, rd_overrun, parity_err
  );
  modport slave (
    input  rom_read_enable, pc, prog_we, prog_addr, prog_data, prog_par_inv,
    output rd_data, rd_valid, busy, rd_overrun, parity_err
  );
`else
  modport master (
    output rom_read_enable, pc, prog_we, prog_addr, prog_data,
    input  rd_data, rd_valid, busy, rd_overrun
  );
  modport slave (
    input  rom_read_enable, pc, prog_we, prog_addr, prog_data,
    output rd_data, rd_valid, busy, rd_overrun
  );
`endif
endinterface

// File: rtl/instr_rom_responder.sv
// Instruction memory responder: fixed-latency reads for the fetch path plus a program-load write port.
// Optional ROM_PARITY_EN stores an even-parity bit per word and flags mismatches on each response.
module instr_rom_responder #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input logic                 clk,
  input logic                 reset,
  instr_rom_responder_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [DATA_W-1:0] hold, hold_nxt;
  logic              overrun_set;
  logic [DATA_W-1:0] mem [DEPTH];
`ifdef ROM_PARITY_EN
  logic              mem_par [DEPTH];
  logic              hold_par, hold_par_nxt;
`endif

  // Program-load port; memory survives reset
  always_ff @(posedge clk) begin
    if (bus.prog_we) begin
      mem[bus.prog_addr] <= bus.prog_data;
`ifdef ROM_PARITY_EN
      mem_par[bus.prog_addr] <= (^bus.prog_data) ^ bus.prog_par_inv;
`endif
    end
  end

  // Next-state: RESP behaves as IDLE for a fresh request, so reads can chain
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    hold_nxt    = hold;
    overrun_set = 1'b0;
`ifdef ROM_PARITY_EN
    hold_par_nxt = hold_par;
`endif
    case (state)
      IDLE, RESP: begin
        state_nxt = IDLE;
        if (bus.rom_read_enable) begin
          hold_nxt  = mem[bus.pc];
`ifdef ROM_PARITY_EN
          hold_par_nxt = mem_par[bus.pc];
`endif
          cnt_nxt   = CNT_LOAD;
          state_nxt = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        overrun_set = bus.rom_read_enable;
        cnt_nxt     = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nxt = RESP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs, all derived from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      hold           <= '0;
      bus.rd_data    <= '0;
      bus.rd_valid   <= 1'b0;
      bus.busy       <= 1'b0;
      bus.rd_overrun <= 1'b0;
`ifdef ROM_PARITY_EN
      hold_par       <= 1'b0;
      bus.parity_err <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      hold         <= hold_nxt;
      bus.rd_valid <= (state_nxt == RESP);
      bus.busy     <= (state_nxt == WAIT);
      if (state_nxt == RESP) bus.rd_data <= hold_nxt;
      if (overrun_set) bus.rd_overrun <= 1'b1;
`ifdef ROM_PARITY_EN
      hold_par       <= hold_par_nxt;
      bus.parity_err <= (state_nxt == RESP) && (hold_par_nxt != (^hold_nxt));
`endif
    end
  end

endmodule
